// File: rtl/if_fetch.sv
// IF stage: owns the PC, fetches over a req/ack bus, and feeds {if_pc, if_inst} to IF/ID.
// Optional misaligned-fetch marking is enabled by defining FETCH_ALIGN_CHK_EN.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic [31:0] ibus_rdata,
   output logic        stallreq,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic        br_pend_q, br_pend_d;
   logic [31:0] br_tgt_q, br_tgt_d;
   logic        cap, adv, misal;
   logic [31:0] seq_pc;

`ifdef FETCH_ALIGN_CHK_EN
   assign misal = (pc_q[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif

   // A branch resolving on the same edge the delay slot is consumed redirects immediately.
   assign cap    = branch_flag & ~stall[2];
   assign seq_pc = cap ? branch_target : (br_pend_q ? br_tgt_q : pc_q + PC_INC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         hold_pc_q   <= '0;
         hold_inst_q <= '0;
         br_pend_q   <= 1'b0;
         br_tgt_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
         br_pend_q   <= br_pend_d;
         br_tgt_q    <= br_tgt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;
      br_pend_d   = br_pend_q;
      br_tgt_d    = br_tgt_q;
      adv         = 1'b0;
      if (cap) begin
         br_pend_d = 1'b1;
         br_tgt_d  = branch_target;
      end
      unique case (state_q)
         FETCH: begin
            if (flush) begin
               pc_d = new_pc;
               // An unacked bus cycle must run to completion at its original address.
               if (!misal && !ibus_ack) begin
                  state_d   = DRAIN;
                  hold_pc_d = pc_q;
               end
            end else if (misal) begin
               adv = ~stall[1];
            end else if (ibus_ack) begin
               if (stall[1]) begin
                  state_d     = HOLD;
                  hold_pc_d   = pc_q;
                  hold_inst_d = ibus_rdata;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d        = new_pc;
               state_d     = FETCH;
               hold_pc_d   = '0;
               hold_inst_d = '0;
            end else if (!stall[1]) begin
               adv     = 1'b1;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (flush) pc_d = new_pc;
            if (ibus_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (adv) begin
         pc_d      = seq_pc;
         br_pend_d = 1'b0;
      end
      if (flush) br_pend_d = 1'b0;
   end

   // Bus request/address kept free of ibus_ack so a slave may ack combinationally.
   assign ibus_req  = ~rst & ((state_q == DRAIN) | ((state_q == FETCH) & ~misal));
   assign ibus_addr = (state_q == DRAIN) ? {hold_pc_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};

   always_comb begin
      stallreq = 1'b0;
      if_pc    = '0;
      if_inst  = '0;
      if_adel  = 1'b0;
      if (!rst) begin
         unique case (state_q)
            FETCH: begin
               if (misal) begin
                  if_pc   = pc_q;
                  if_adel = 1'b1;
               end else begin
                  stallreq = ~ibus_ack;
                  if (ibus_ack && !flush) begin
                     if_pc   = pc_q;
                     if_inst = ibus_rdata;
                  end
               end
            end
            HOLD: begin
               if_pc   = hold_pc_q;
               if_inst = hold_inst_q;
            end
            DRAIN:   stallreq = 1'b1;
            default: stallreq = 1'b0;
         endcase
      end
   end

endmodule
